uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter peripheral; the responder on the mips_uC data bus.
- The CPU (initiator) writes bytes into a small FIFO. The block serialises them as 8N1 frames on `tx`.
- A status register and an interrupt line let firmware poll or wait on completion.
- Sits beside data memory in the uC top level, selected by the address decoder via `ce`.

---
 rtl/uart_tx_mmio.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, status/baud/control
// registers and a level interrupt raised once the queue has fully drained.
module uart_tx_mmio #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 434,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic             irq_en_q, irq_en_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             tx_q, tx_d;
  logic             irq_q, irq_d;

  logic full, empty, bus_wr, push_req, push, pop, bit_end;
  logic unused_wdata;

  assign unused_wdata = ^wdata;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign bus_wr   = ce & we;
  assign push_req = bus_wr & (addr == ADDR_TXDATA);
  assign bit_end  = (cnt_q == '0);
  // A pop is a frame start: from IDLE, or straight out of the last stop-bit clock.
  assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign push     = push_req && (!full || pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    baud_d    = baud_q;
    irq_en_d  = irq_en_q;
    state_d   = state_q;
    shift_d   = shift_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push_req && full && !pop) ovf_d = 1'b1;
    if (bus_wr && (addr == ADDR_STATUS) && wdata[3]) ovf_d = 1'b0;
    if (bus_wr && (addr == ADDR_BAUD))
      baud_d = (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];
    if (bus_wr && (addr == ADDR_CTRL)) irq_en_d = wdata[0];

    case (state_q)
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          cnt_d     = div_q - 1'b1;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_q - 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (!bit_end)   cnt_d   = cnt_q - 1'b1;
        else if (!pop)  state_d = S_IDLE;
      end
      default: ;
    endcase

    // Frame start: divisor is captured here so BAUD writes only affect later frames.
    if (pop) begin
      state_d = S_START;
      shift_d = mem_q[rd_ptr_q];
      div_d   = baud_q;
      cnt_d   = baud_q - 1'b1;
      tx_d    = 1'b0;
    end
  end

  assign irq_d = irq_en_q & empty & (state_q == S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      baud_q    <= DIV_W'(DEFAULT_DIV);
      irq_en_q  <= 1'b0;
      state_q   <= S_IDLE;
      shift_q   <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      baud_q    <= baud_d;
      irq_en_q  <= irq_en_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

  // NOTE: FIFO storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (ce && !we) begin
      case (addr)
        ADDR_STATUS: rdata = {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, (state_q != S_IDLE)};
        ADDR_BAUD:   rdata = 32'(baud_q);
        ADDR_CTRL:   rdata = {31'h0, irq_en_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a frame-level reference model feeds a
// scoreboard queue that a tx-line monitor drains and compares against.
module tb_uart_tx_mmio;

  localparam int FIFO_DEPTH  = 4;
  localparam int DEFAULT_DIV = 434;
  localparam int DIV_W       = 16;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  uart_tx_mmio #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DEFAULT_DIV(DEFAULT_DIV),
    .DIV_W      (DIV_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .tx   (tx),
    .irq  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the peripheral.
  typedef struct {
    logic [7:0] data;
    int         div;
    int         start;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] m_fifo[$];
  int         m_div    = DEFAULT_DIV;
  bit         m_active = 1'b0;
  int         m_end    = 0;
  bit         m_ovf    = 1'b0;
  bit         m_irq_en = 1'b0;
  logic       m_irq    = 1'b0;
  int         cyc      = 0;
  bit         mon_abort = 1'b0;
  bit         mon_en    = 1'b0;
  int         irq_err   = 0;

  initial begin
    bit         frame_done;
    bit         do_pop;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        m_fifo.delete();
        exp_q.delete();
        m_active  = 1'b0;
        m_ovf     = 1'b0;
        m_irq_en  = 1'b0;
        m_div     = DEFAULT_DIV;
        m_irq     = 1'b0;
        mon_abort = 1'b1;
      end else begin
        m_irq      = m_irq_en && (m_fifo.size() == 0) && !m_active;
        frame_done = m_active && (cyc == m_end);
        do_pop     = (m_fifo.size() > 0) && (!m_active || frame_done);
        if (frame_done) m_active = 1'b0;
        if (do_pop) begin
          b = m_fifo.pop_front();
          exp_q.push_back('{data: b, div: m_div, start: cyc});
          m_active = 1'b1;
          m_end    = cyc + 10 * m_div;
        end
        if (ce && we) begin
          case (addr)
            2'd0: if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(wdata[7:0]);
                  else m_ovf = 1'b1;
            2'd1: if (wdata[3]) m_ovf = 1'b0;
            2'd2: m_div = (wdata[15:0] == 16'd0) ? 1 : int'(wdata[15:0]);
            default: m_irq_en = wdata[0];
          endcase
        end
      end
    end
  end

  function automatic logic [31:0] exp_status();
    logic [7:0] cnt;
    logic       e_empty, e_full, e_busy, e_ovf;
    cnt     = 8'(m_fifo.size());
    e_empty = (m_fifo.size() == 0);
    e_full  = (m_fifo.size() == FIFO_DEPTH);
    e_busy  = m_active;
    e_ovf   = m_ovf;
    return {16'h0, cnt, 4'h0, e_ovf, e_empty, e_full, e_busy};
  endfunction

  // Monitor: decodes the tx line and retires scoreboard entries.
  initial begin
    frame_t     cur;
    bit         in_frame;
    int         k, bit_err, slot;
    logic [7:0] dec;
    logic       expb;
    in_frame = 1'b0;
    k = 0; bit_err = 0; dec = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mon_abort) begin
          in_frame  = 1'b0;
          mon_abort = 1'b0;
        end
        if (irq !== m_irq) irq_err++;
        if (!in_frame && (tx !== 1'b1)) begin
          if (tx === 1'b0 && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("frame_start_cycle", cyc, cur.start);
            in_frame = 1'b1;
            k = 0; bit_err = 0; dec = '0;
          end else begin
            check("idle_tx", {31'h0, tx}, 32'h1);
          end
        end
        if (in_frame) begin
          slot = k / cur.div;
          if (slot == 0)      expb = 1'b0;
          else if (slot == 9) expb = 1'b1;
          else                expb = cur.data[slot-1];
          if (tx !== expb) bit_err++;
          if ((slot >= 1) && (slot <= 8) && ((k % cur.div) == (cur.div / 2))) dec[slot-1] = tx;
          k++;
          if (k == 10 * cur.div) begin
            check("frame_bits", bit_err, 0);
            check("frame_data", {24'h0, dec}, {24'h0, cur.data});
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    ce = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    logic [31:0] s;
    bit          done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      bus_read(2'd1, s);
      if (!s[0] && s[2]) done = 1'b1;
      else tick(1);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles", max_cycles);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int          d, n;
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
    tick(2);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h0);
    bus_read(2'd1, r); check("reset_status", r, 32'h4);
    bus_read(2'd2, r); check("reset_baud", r, 32'd434);
    bus_read(2'd3, r); check("reset_ctrl", r, 32'h0);
    bus_read(2'd0, r); check("txdata_reads_zero", r, 32'h0);

    // Single byte 0xA5 at divisor 4
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'hA5);
    tick(1);
    check("single_tx_start_next_edge", {31'h0, tx}, 32'h0);
    tick(39);
    bus_read(2'd1, r); check("single_busy_at_39", {31'h0, r[0]}, 32'h1);
    tick(1);
    bus_read(2'd1, r); check("single_busy_clear_at_40", {31'h0, r[0]}, 32'h0);

    // Reset mid-frame discards the frame and queued bytes
    bus_write(2'd0, 32'h33);
    bus_write(2'd0, 32'h44);
    tick(15);
    rst = 1'b1;
    tick(1);
    check("midreset_tx", {31'h0, tx}, 32'h1);
    tick(1);
    rst = 1'b0;
    bus_read(2'd1, r); check("midreset_status", r, 32'h4);
    bus_read(2'd2, r); check("midreset_baud", r, 32'd434);
    tick(3);
    check("midreset_tx_stays_idle", {31'h0, tx}, 32'h1);

    // Back-to-back frames
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h01);
    bus_write(2'd0, 32'h02);
    bus_write(2'd0, 32'h03);
    bus_read(2'd1, r); check("b2b_count_2", {24'h0, r[15:8]}, 32'd2);
    tick(39);
    bus_read(2'd1, r); check("b2b_count_1", {24'h0, r[15:8]}, 32'd1);
    tick(40);
    bus_read(2'd1, r); check("b2b_count_0", {24'h0, r[15:8]}, 32'd0);
    wait_idle(200);

    // Overflow
    bus_write(2'd2, 32'd100);
    for (int i = 0; i < 6; i++) bus_write(2'd0, 32'h10 + i);
    bus_read(2'd1, r); check("overflow_status", r, 32'h0000040B);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, r); check("overflow_cleared", r, 32'h00000403);
    wait_idle(6000);

    // Baud change mid-frame: 40-clock frame then 80-clock frame
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h55);
    tick(11);
    bus_write(2'd2, 32'd8);
    bus_write(2'd0, 32'hAA);
    tick(27);
    check("baud_first_stop_bit", {31'h0, tx}, 32'h1);
    tick(1);
    check("baud_second_start", {31'h0, tx}, 32'h0);
    tick(5);
    check("baud_second_start_held", {31'h0, tx}, 32'h0);
    tick(74);
    bus_read(2'd1, r); check("baud_second_busy_79", {31'h0, r[0]}, 32'h1);
    tick(1);
    bus_read(2'd1, r); check("baud_second_done_80", {31'h0, r[0]}, 32'h0);
    bus_read(2'd2, r); check("baud_readback", r, 32'd8);

    // irq
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'h1);
    bus_write(2'd0, 32'h3C);
    tick(1);
    check("irq_low_frame_start", {31'h0, irq}, 32'h0);
    tick(20);
    check("irq_low_mid_frame", {31'h0, irq}, 32'h0);
    tick(20);
    check("irq_low_at_idle_return", {31'h0, irq}, 32'h0);
    tick(1);
    check("irq_high_after_idle", {31'h0, irq}, 32'h1);
    bus_read(2'd3, r); check("ctrl_readback", r, 32'h1);
    bus_write(2'd3, 32'h0);
    tick(1);
    check("irq_dropped", {31'h0, irq}, 32'h0);

    // Randomized traffic against the model
    for (int it = 0; it < 25; it++) begin
      wait_idle(2000);
      d = $urandom_range(0, 5);
      bus_write(2'd2, {16'($urandom), 16'(d)});
      bus_read(2'd2, r); check("rand_baud", r, 32'(m_div));
      bus_write(2'd3, $urandom);
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++) begin
        bus_write(2'd0, $urandom);
        if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
      end
      bus_read(2'd1, r); check("rand_status", r, exp_status());
      if ($urandom_range(0, 1) == 1) bus_write(2'd1, 32'h8);
      else bus_write(2'd1, $urandom & 32'hFFFF_FFF7);
      bus_read(2'd1, r); check("rand_status_after_w1c", r, exp_status());
    end
    wait_idle(2000);
    bus_write(2'd3, 32'h0);
    tick(3);

    check("irq_track_errors", irq_err, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
